// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl: NBYTES-wide adder built from one 8-bit adder stepped LSB-first, one byte per clock
module fullAdder8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {8'b0, ci};
endmodule

module byte_serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                ready,
  output logic                busy,
  input  logic [8*NBYTES-1:0] add,
  input  logic [8*NBYTES-1:0] aug,
  input  logic                preC,
  output logic [8*NBYTES-1:0] sum,
  output logic                proC,
  output logic                done
);
  localparam int W  = 8*NBYTES;
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  add_q, aug_q;
  logic          carry_q, c_nx;
  logic [7:0]    s_b;
  fullAdder8bit u_fa (
    .a (add_q[8*idx +: 8]),
    .b (aug_q[8*idx +: 8]),
    .ci(carry_q),
    .s (s_b),
    .co(c_nx)
  );
  assign ready = state != RUN;
  assign busy  = state == RUN;
  assign done  = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      add_q   <= '0;
      aug_q   <= '0;
      sum     <= '0;
      proC    <= 1'b0;
    end else if (state == RUN) begin
      sum[8*idx +: 8] <= s_b;
      carry_q         <= c_nx;
      if (idx == IW'(NBYTES-1)) begin
        proC  <= c_nx;
        state <= DONE;
      end else
        idx <= idx + 1'b1;
    end else if (start) begin
      add_q   <= add;
      aug_q   <= aug;
      carry_q <= preC;
      idx     <= '0;
      state   <= RUN;
    end else
      state <= IDLE;
  end
endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// tb_byte_serial_add_ctrl: scoreboard bench for 4-byte and 1-byte instances of byte_serial_add_ctrl
module tb_byte_serial_add_ctrl;
  typedef struct {logic [32:0] v; int c;} exp_t;
  logic clk = 0, rst_n = 0;
  logic start = 0, start1 = 0;
  logic [31:0] add = 0, aug = 0, sum;
  logic [7:0] add1 = 0, aug1 = 0, sum1;
  logic preC = 0, preC1 = 0;
  logic ready, busy, done, proC, ready1, busy1, done1, proC1;
  exp_t q4[$], q1[$];
  exp_t e4, e1;
  int cyc = 0, n_cmp = 0, n_bad = 0;

  byte_serial_add_ctrl #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .busy(busy),
    .add(add), .aug(aug), .preC(preC), .sum(sum), .proC(proC), .done(done)
  );
  byte_serial_add_ctrl #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1), .busy(busy1),
    .add(add1), .aug(aug1), .preC(preC1), .sum(sum1), .proC(proC1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (done) begin
      if (q4.size() == 0) chk("spurious_done4", 33'(done), 33'd0);
      else begin
        e4 = q4.pop_front();
        chk("result4", {proC, sum}, e4.v);
        chk("done_cycle4", 33'(cyc), 33'(e4.c));
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("spurious_done1", 33'(done1), 33'd0);
      else begin
        e1 = q1.pop_front();
        chk("result1", {24'b0, proC1, sum1}, e1.v);
        chk("done_cycle1", 33'(cyc), 33'(e1.c));
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [32:0] ev, input bit noise);
    @(negedge clk);
    start = 1; add = a; aug = b; preC = c;
    q4.push_back('{v: ev, c: cyc + 5});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_run", 33'(busy), 33'd1);
      chk("ready_run", 33'(ready), 33'd0);
      start = noise && i < 3;
      if (noise) begin add = 32'hDEADBEEF; aug = ~aug; preC = ~preC; end
    end
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [32:0] ev);
    @(negedge clk);
    start1 = 1; add1 = a; aug1 = b; preC1 = c;
    q1.push_back('{v: ev, c: cyc + 2});
    @(negedge clk);
    chk("busy1_run", 33'(busy1), 33'd1);
    start1 = 0; add1 = ~add1;
  endtask

  initial begin
    start = 1; add = $urandom; aug = $urandom; preC = 1;
    start1 = 1; add1 = 8'($urandom); aug1 = 8'($urandom); preC1 = 1;
    repeat (3) @(negedge clk);
    chk("rst_sum", {1'b0, sum}, 33'd0);
    chk("rst_proC", 33'(proC), 33'd0);
    chk("rst_done", 33'(done), 33'd0);
    chk("rst_ready", 33'(ready), 33'd1);
    chk("rst_busy", 33'(busy), 33'd0);
    chk("rst_sum1", {25'b0, sum1}, 33'd0);
    chk("rst_ready1", 33'(ready1), 33'd1);
    start = 0; start1 = 0;
    rst_n = 1;
    run_op(32'h12345678, 32'h11111111, 0, {1'b0, 32'h23456789}, 0);
    repeat (2) @(negedge clk);
    run_op(32'hFFFFFFFF, 32'h00000000, 1, {1'b1, 32'h0}, 0);
    repeat (2) @(negedge clk);
    run_op(32'h80000000, 32'h80000000, 0, {1'b1, 32'h0}, 0);
    repeat (2) @(negedge clk);
    run_op(32'h01020304, 32'h10203040, 0, {1'b0, 32'h11223344}, 1);
    repeat (3) @(negedge clk);
    run_op(32'h12345678, 32'h11111111, 0, {1'b0, 32'h23456789}, 0);
    run_op(32'h000000FF, 32'h00000001, 0, {1'b0, 32'h00000100}, 0);
    repeat (2) @(negedge clk);
    // abort: reset lands mid second RUN cycle, between edges
    start = 1; add = 32'h11223344; aug = 32'h01010101; preC = 0;
    @(negedge clk);
    start = 0;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_sum", {1'b0, sum}, 33'd0);
    chk("abort_proC", 33'(proC), 33'd0);
    chk("abort_busy", 33'(busy), 33'd0);
    chk("abort_ready", 33'(ready), 33'd1);
    chk("abort_done", 33'(done), 33'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_op(32'h0000FFFF, 32'h00000001, 0, {1'b0, 32'h00010000}, 0);
    repeat (2) @(negedge clk);
    run1(8'hFF, 8'h01, 0, 33'h100);
    run1(8'h12, 8'h34, 1, 33'h047);
    repeat (2) @(negedge clk);
    run1(8'h80, 8'h7F, 0, 33'h0FF);
    for (int i = 0; i < 20 && (q4.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk("drain4", 33'(q4.size()), 33'd0);
    chk("drain1", 33'(q1.size()), 33'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/byte_serial_add_ctrl.md
Name: byte_serial_add_ctrl

Overview:
- Sequencer that performs an NBYTES-wide addition by time-multiplexing a single fullAdder8bit instance, one byte per clock, LSB first.
- The carry is held in a register between bytes.
- Sits between a requester, which uses a start/ready/done handshake, and the 8-bit adder datapath.
- Trades throughput for area: one adder instead of NBYTES adders.

Parameters:
- NBYTES, 4, operand width in bytes (>=1). Derived W = 8*NBYTES.
- Byte index counter width = max(1, clog2(NBYTES)).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- ready  output  1  controller can accept start (IDLE or DONE state)
- busy  output  1  high in RUN state
- add  input  W  addend, sampled on accepted start
- aug  input  W  augend, sampled on accepted start
- preC  input  1  carry-in, sampled on accepted start
- sum  output  W  registered result
- proC  output  1  registered carry-out of MSB byte
- done  output  1  one-cycle pulse; sum/proC valid

Behaviour:
- Datapath: exactly one fullAdder8bit instance. Its inputs are byte[idx] of the captured add/aug, plus carry_q. Its outputs are sum byte and carry next.
- Reset (async, rst_n=0): state=IDLE, idx=0, carry_q=0, sum=0, proC=0, done=0. Combinationally, ready=1 and busy=0.
- States: IDLE, RUN, DONE. Encoding is free. ready=(state!=RUN), busy=(state==RUN), done=(state==DONE).
- IDLE: on start=1 at an edge:
  - capture add_q<=add, aug_q<=aug, carry_q<=preC, idx<=0.
  - go to RUN.
  - Otherwise hold.
- RUN, each edge:
  - sum[8*idx+:8] <= adder sum; carry_q <= adder carry-out.
  - If idx==NBYTES-1: proC <= adder carry-out, go to DONE. Otherwise idx<=idx+1.
- DONE: lasts exactly one cycle (done=1).
  - start=1: capture as in IDLE, go to RUN (back-to-back operation).
  - start=0: go to IDLE.
- Latency: start accepted at edge E → RUN for edges E+1..E+NBYTES → done high in the cycle after edge E+NBYTES.
- Throughput: one operation per NBYTES+1 cycles.
- start while busy: ignored. No queueing, no effect on the current operation.
- add/aug/preC changes after capture: no effect.
- sum/proC:
  - Held stable from DONE until the next accepted start.
  - During RUN, sum holds a mix of new low bytes and stale high bytes; the requester must not use it.
- Arithmetic: {proC,sum} = add + aug + preC, modulo 2^(W+1). The carry ripples across byte boundaries through carry_q only.
- NBYTES=1: single RUN cycle; idx stays 0; done one cycle after the RUN edge.
- Reset asserted mid-RUN or in DONE: immediate abort to reset values. The partial result is discarded. No done pulse.
- Reset deasserted with start=1: start is evaluated at the first clock edge after release.

Test Plan:
- Reset: hold rst_n=0 with random inputs → sum=0, proC=0, done=0, ready=1, busy=0. Assert rst_n asynchronously between edges → outputs clear without a clock edge.
- NBYTES=4: add=0x12345678, aug=0x11111111, preC=0, start pulse at edge E → busy during E+1..E+4, done=1 exactly one cycle after E+4, sum=0x23456789, proC=0.
- Full carry ripple: add=0xFFFFFFFF, aug=0x00000000, preC=1 → sum=0x00000000, proC=1. Also add=0x80000000, aug=0x80000000, preC=0 → sum=0, proC=1.
- Ignore rules: start pulses and operand changes (add=0xDEADBEEF) during RUN → first result unchanged, exactly one done pulse, no extra operation.
- Back-to-back: second start held high in the DONE cycle with add=0x000000FF, aug=0x00000001, preC=0 → done again NBYTES+1 cycles after the first done, sum=0x00000100, proC=0. The first result stays visible in the DONE cycle.
- Abort: rst_n=0 at the 2nd RUN cycle → sum=0, no done. After release, a new operation with add=0x0000FFFF, aug=0x00000001 → sum=0x00010000, proC=0. Repeat the directed cases with NBYTES=1 (add=0xFF, aug=0x01 → sum=0x00, proC=1).
